// File: rtl/serial_paralelo_rx_if.sv
// Bus interface for serial_paralelo_rx.
//   data_in      serial bit stream, MSB of each byte first (master -> slave)
//   data_out     last received byte (slave -> master)
//   valid_out    data_out holds a non-comma byte
//   active       receiver is locked
//   misalign_err single-cycle pulse on a misaligned comma (only with SP_RX_REALIGN_EN)
// Macro: SP_RX_REALIGN_EN adds the misalign_err signal.
interface serial_paralelo_rx_if;
  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
`ifdef SP_RX_REALIGN_EN
  logic       misalign_err;
`endif

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
`ifdef SP_RX_REALIGN_EN
    , input misalign_err
`endif
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
`ifdef SP_RX_REALIGN_EN
    , output misalign_err
`endif
  );
endinterface

// File: rtl/serial_paralelo_rx.sv
// Serial-to-parallel receiver, far end of the PHY serial link.
// Samples one bit per clk_32f edge (MSB first), byte-aligns on the idle
// comma, and after BC_COUNT consecutive aligned commas presents each byte
// on data_out, with valid_out low for commas.
// Ports:
//   clk_32f  serial bit clock, rising edge
//   reset    synchronous, active-high
//   bus      serial_paralelo_rx_if.slave (data_in, data_out, valid_out,
//            active, misalign_err when enabled)
// Macro: SP_RX_REALIGN_EN -- drop lock on a comma seen off the byte boundary
//   and pulse misalign_err; otherwise lock is left only by reset.
module serial_paralelo_rx #(
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter int unsigned BC_COUNT = 4
) (
  input  logic clk_32f,
  input  logic reset,
  serial_paralelo_rx_if.slave bus
);

  typedef enum logic [1:0] {INIT, ALIGN, ACTIVE} state_t;

  localparam logic [3:0] BC_TGT = 4'(BC_COUNT);

  state_t     state, state_n;
  logic [7:0] sr;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [3:0] bc_cnt, bc_cnt_n;
  logic [7:0] data_q, data_n;
  logic       valid_q, valid_n;
  logic       active_q, active_n;
  logic [7:0] byte_now;
  logic       boundary;
  logic       is_comma;
`ifdef SP_RX_REALIGN_EN
  logic       mis_q, mis_n;
`endif

  // Byte completed by the bit sampled at this edge.
  assign byte_now = {sr[6:0], bus.data_in};
  assign boundary = (bit_cnt == 3'd7);
  assign is_comma = (byte_now == COMMA);

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state    <= INIT;
      sr       <= '0;
      bit_cnt  <= '0;
      bc_cnt   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
`ifdef SP_RX_REALIGN_EN
      mis_q    <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      sr       <= byte_now;
      bit_cnt  <= bit_cnt_n;
      bc_cnt   <= bc_cnt_n;
      data_q   <= data_n;
      valid_q  <= valid_n;
      active_q <= active_n;
`ifdef SP_RX_REALIGN_EN
      mis_q    <= mis_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt + 3'd1;
    bc_cnt_n  = bc_cnt;
    data_n    = data_q;
    valid_n   = valid_q;
    active_n  = active_q;
`ifdef SP_RX_REALIGN_EN
    mis_n     = 1'b0;
`endif
    case (state)
      INIT: begin
        // Bit position unknown: look for the comma at every edge.
        valid_n   = 1'b0;
        active_n  = 1'b0;
        bit_cnt_n = bit_cnt;
        if (is_comma) begin
          bit_cnt_n = '0;
          bc_cnt_n  = 4'd1;
          if (BC_TGT == 4'd1) begin
            state_n  = ACTIVE;
            active_n = 1'b1;
          end else begin
            state_n = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (is_comma) begin
            bc_cnt_n = bc_cnt + 4'd1;
            if (bc_cnt + 4'd1 == BC_TGT) begin
              state_n  = ACTIVE;
              active_n = 1'b1;
            end
          end else begin
            state_n  = INIT;
            bc_cnt_n = '0;
          end
        end
      end
      ACTIVE: begin
        active_n = 1'b1;
        if (boundary) begin
          data_n  = byte_now;
          valid_n = !is_comma;
        end
`ifdef SP_RX_REALIGN_EN
        else if (is_comma) begin
          state_n  = INIT;
          active_n = 1'b0;
          valid_n  = 1'b0;
          bc_cnt_n = '0;
          mis_n    = 1'b1;
        end
`endif
      end
      default: state_n = INIT;
    endcase
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.active    = active_q;
`ifdef SP_RX_REALIGN_EN
  assign bus.misalign_err = mis_q;
`endif

endmodule

// File: doc/serial_paralelo_rx.md
Name: serial_paralelo_rx

Overview:
- Serial-to-parallel receiver; the far end of the PHY serial link.
- Samples one bit per clk_32f cycle, MSB first.
- Byte-aligns on the idle comma 8'hBC, which the transmitter sends whenever it has no valid data.
- After lock, presents each received byte on data_out with valid_out, deasserting valid_out for idle commas.

Parameters:
- COMMA, 8'hBC, idle/alignment symbol.
- BC_COUNT, 4, consecutive aligned commas required to declare lock (legal range 1..15).

Ports:
- clk_32f  input  1  serial bit clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  1  serial bit stream, MSB of each byte first.
- data_out  output  8  last received byte (parallel).
- valid_out  output  1  data_out holds a non-comma byte.
- active  output  1  receiver is locked (state ACTIVE).

Behaviour:
- Shift register sr[7:0]: sr <= {sr[6:0], data_in} every cycle, in every state except reset.
- Define byte_now = {sr[6:0], data_in}, i.e. the byte completed at the current edge.
- Reset (reset=1 at an edge):
  - sr=0, bit_cnt=0, bc_cnt=0, state=INIT.
  - data_out=8'h00, valid_out=0, active=0.
  - Reset asserted mid-byte or mid-lock discards everything immediately; no partial byte is output.
- State INIT (hunting; bit position unknown):
  - Compare byte_now against COMMA on every edge.
  - On match: bit_cnt <= 0 (next sample is bit 7 of the next byte), bc_cnt <= 1.
  - On match with BC_COUNT==1: go directly to ACTIVE.
  - On match otherwise: go to ALIGN.
  - Outputs stay valid_out=0, active=0; data_out holds its value.
- State ALIGN (counting commas):
  - bit_cnt increments each cycle, wrapping 7->0.
  - A byte boundary is the edge where bit_cnt==7.
  - At a boundary with byte_now==COMMA: bc_cnt+1; if bc_cnt+1==BC_COUNT, go to ACTIVE.
  - At a boundary with byte_now!=COMMA: go to INIT, bc_cnt=0.
  - Only bit-aligned commas count. Shifted comma patterns are ignored here.
- State ACTIVE (locked):
  - bit_cnt keeps free-running 0..7.
  - At each boundary: data_out <= byte_now and valid_out <= (byte_now != COMMA).
  - Both outputs are held for exactly 8 cycles, until the next boundary.
  - active=1, registered; it rises on the edge that enters ACTIVE.
  - Without the optional feature, lock is left only by reset.
- Latency:
  - data_out/valid_out update on the same edge that samples the byte's LSB.
  - Visible one cycle after the LSB is on data_in.
- First output after lock: the byte following the BC_COUNT-th comma. The locking commas themselves are never output with valid_out=1.
- bc_cnt saturates at BC_COUNT; bit_cnt is 3 bits, naturally wrapping.

Optional Feature:
- Macro: SP_RX_REALIGN_EN.
- Defined:
  - In ACTIVE, if byte_now==COMMA at an edge where bit_cnt!=7, the comma is misaligned.
  - The block returns to INIT on the next edge with active=0 and valid_out=0; data_out holds.
  - Adds output misalign_err (1 bit), a single-cycle pulse on that edge; reset value 0.
  - Data patterns that mimic a shifted comma also trigger this. That is accepted behaviour.
- Undefined:
  - No misalign_err port.
  - ACTIVE is held until reset regardless of shifted comma patterns.

Test Plan:
- Lock: reset 2 cycles, then send 8'hBC x4 MSB-first -> active rises on the edge sampling the LSB of the 4th comma; valid_out=0 throughout.
- Data: after lock send 8'hA5, 8'h3C, 8'hBC -> data_out=8'hA5 then 8'h3C (valid_out=1, each held 8 cycles), then valid_out=0 with data_out=8'hBC.
- Broken sequence: send BC, BC, 8'h11, BC, BC, BC, BC -> lock only after the final 4 consecutive commas; active rises 8*7 bit-times after start (on the last LSB).
- Arbitrary phase: 3 random bits then BC x4, 8'h5A -> lock achieved; data_out=8'h5A, valid_out=1.
- Reset mid-operation: assert reset during bit 4 of a data byte in ACTIVE -> next edge active=0, valid_out=0, data_out=8'h00; BC x4 is needed to relock.
- SP_RX_REALIGN_EN: locked stream, then insert 3 extra bits before BC x4 -> misalign_err pulses once, active drops, relock after 4 aligned commas; with the macro undefined, active stays 1.
